ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- Receives the PS/2 keyboard serial stream (device-to-host) and decodes each 11-bit frame.
- Filters set-2 prefixes (E0, F0) and typematic repeats.
- Presents a one-cycle `flagkey` strobe with a stable `scancode` to the pixel-effect blocks. Each physical key press produces exactly one strobe.
- Sits between the board PS/2 pins and every `scancode`/`flagkey` consumer.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles with no ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).
- SUPPRESS_REPEAT, 1: 1 = repeated make codes of the held key produce no strobe; 0 = every make code strobes.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from pin, asynchronous.
- ps2_data  in  1  raw PS/2 data from pin, asynchronous.
- scancode  out  8  last accepted make code; held until the next accepted make.
- flagkey  out  1  one-cycle strobe: new make code on `scancode`.
- extended  out  1  1 if the current `scancode` was preceded by E0; updates with `scancode`.
- keyrelease  out  1  one-cycle strobe on a completed break (F0 xx) sequence.
- frame_err  out  1  one-cycle strobe on a parity, stop or timeout error.

Behaviour:
- Reset (async): scancode=0, flagkey=0, extended=0, keyrelease=0, frame_err=0. Also FSM=IDLE, bit count=0, timeout counter=0, brk_pend=0, ext_pend=0, held_valid=0. Reset mid-frame discards the partial frame.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is detected when the previous synced clk is 1 and the current synced clk is 0. Synced data is sampled in that same cycle.
- Frame FSM:
  - IDLE: on a falling edge with data=0 (start bit) go to DATA, bit count=0. A start bit of 1 is ignored; stay in IDLE with no error.
  - DATA: shift 8 bits LSB first, one per falling edge. After the 8th bit go to PARITY.
  - PARITY: sample the parity bit. Go to STOP.
  - STOP: on a falling edge, the frame is good if stop=1 and (XOR of 8 data bits and parity)=1 (odd parity). Otherwise pulse frame_err. Return to IDLE either way.
- Timeout:
  - The counter clears on every falling edge and increments while FSM != IDLE.
  - When it reaches TIMEOUT_CYCLES: FSM goes to IDLE, frame_err pulses, brk_pend and ext_pend clear.
  - The counter does not run in IDLE.
- Any frame_err clears brk_pend and ext_pend.
- Byte decode runs on a good frame. Outputs change in the cycle after the stop-bit falling edge is detected (latency 1 clk from detection, 3 clk from the pin edge).
  - byte=F0: brk_pend=1. No strobe.
  - byte=E0: ext_pend=1. No strobe.
  - Other byte with brk_pend=1: keyrelease pulses. If held_valid and byte==held_code, then held_valid=0. scancode and extended are unchanged. Clear both pends.
  - Other byte with brk_pend=0: if SUPPRESS_REPEAT=1 and held_valid and byte==held_code, no strobe. Otherwise scancode=byte, extended=ext_pend, flagkey pulses, held_code=byte, held_valid=1. Clear both pends.
- A make code of a different key while one is held is accepted and becomes held_code. A release of a non-held key strobes keyrelease only.
- flagkey, keyrelease and frame_err are never high for more than 1 cycle. No two of them are high in the same cycle.
- No host-to-device transmission; ps2_clk and ps2_data are inputs only.

Test Plan:
- Make F: frame start0, data 0x2B LSB-first (1,1,0,1,0,1,0,0), parity 1, stop 1 -> exactly one flagkey pulse; scancode=8'h2B; extended=0; frame_err=0.
- Break F: frames F0 then 2B after a 2B make -> no flagkey; one keyrelease pulse after the 2B frame; scancode stays 8'h2B; a following 2B make strobes flagkey again.
- Typematic, SUPPRESS_REPEAT=1: frames 2D,2D,2D -> one flagkey. Then F0,2D,2D -> keyrelease once, then a second flagkey. With SUPPRESS_REPEAT=0: 2D,2D,2D -> three flagkey pulses.
- Parity error: 0x2D sent with parity 0 -> one frame_err pulse, no flagkey, scancode unchanged. A next good 0x2B frame -> flagkey with scancode=8'h2B.
- Timeout: start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 -> one frame_err pulse, FSM in IDLE. A following good 0x2D frame -> flagkey with scancode=8'h2D.
- Extended and reset: frames E0,75 -> flagkey, scancode=8'h75, extended=1. Assert reset during bit 5 of the next frame -> all outputs 0 immediately. The next full 0x2B frame decodes normally with extended=0.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames device-to-host bytes and turns set-2 make/break
// sequences into single-cycle key strobes with prefix and typematic filtering.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       flagkey,
    output logic       extended,
    output logic       keyrelease,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic          fall, din;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          brk_pend, brk_n, ext_pend, ext_n;
    logic          held_valid, hv_n;
    logic [7:0]    held_code, hc_n;
    logic [7:0]    sc_n;
    logic          ex_n, fk_n, kr_n, fe_n;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign din  = dat_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            held_valid <= 1'b0;
            held_code  <= '0;
            scancode   <= '0;
            extended   <= 1'b0;
            flagkey    <= 1'b0;
            keyrelease <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            tcnt       <= tcnt_n;
            brk_pend   <= brk_n;
            ext_pend   <= ext_n;
            held_valid <= hv_n;
            held_code  <= hc_n;
            scancode   <= sc_n;
            extended   <= ex_n;
            flagkey    <= fk_n;
            keyrelease <= kr_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        brk_n    = brk_pend;
        ext_n    = ext_pend;
        hv_n     = held_valid;
        hc_n     = held_code;
        sc_n     = scancode;
        ex_n     = extended;
        fk_n     = 1'b0;
        kr_n     = 1'b0;
        fe_n     = 1'b0;

        if (state == IDLE || fall)
            tcnt_n = '0;
        else
            tcnt_n = tcnt + 1'b1;

        // Abort in the cycle the counter would reach TIMEOUT_CYCLES.
        if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tcnt_n  = '0;
            fe_n    = 1'b1;
            brk_n   = 1'b0;
            ext_n   = 1'b0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n  = {din, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_n = PARITY;
                end
                PARITY: begin
                    par_n   = din;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!din || !((^shreg) ^ par)) begin
                        fe_n  = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end else if (shreg == 8'hF0) begin
                        brk_n = 1'b1;
                    end else if (shreg == 8'hE0) begin
                        ext_n = 1'b1;
                    end else if (brk_pend) begin
                        kr_n  = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                        if (held_valid && shreg == held_code)
                            hv_n = 1'b0;
                    end else begin
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                        // Typematic repeats of the held key are swallowed.
                        if (!(SUPPRESS_REPEAT && held_valid && shreg == held_code)) begin
                            sc_n = shreg;
                            ex_n = ext_pend;
                            fk_n = 1'b1;
                            hc_n = shreg;
                            hv_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench: drives PS/2 frames into repeat-suppressing and non-suppressing
// receivers and checks strobe counts and held outputs after each step.
module tb_ps2_keyboard_rx;
    localparam int TO   = 1000;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode, scancode0;
    logic       flagkey, extended, keyrelease, frame_err;
    logic       flagkey0, extended0, keyrelease0, frame_err0;

    int n_cmp = 0, n_err = 0;
    int fk1 = 0, fk0 = 0, rel1 = 0, err1 = 0, ovl = 0;
    int b_fk1, b_fk0, b_rel, b_err;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode), .flagkey(flagkey), .extended(extended),
        .keyrelease(keyrelease), .frame_err(frame_err));

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode0), .flagkey(flagkey0), .extended(extended0),
        .keyrelease(keyrelease0), .frame_err(frame_err0));

    always @(negedge clk) begin
        if (flagkey)    fk1++;
        if (flagkey0)   fk0++;
        if (keyrelease) rel1++;
        if (frame_err)  err1++;
        if (int'(flagkey) + int'(keyrelease) + int'(frame_err) > 1) ovl++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_fk1 = fk1; b_fk0 = fk0; b_rel = rel1; b_err = err1;
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic stp, input int nbits);
        logic [10:0] f;
        f = {stp, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send(b, ~^b, 1'b1, 11);
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_scancode", 32'(scancode), 32'h0);
        chk("rst_flagkey", 32'(flagkey), 32'h0);
        chk("rst_extended", 32'(extended), 32'h0);
        chk("rst_keyrelease", 32'(keyrelease), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        wait_cyc(5);

        // Make 2B
        mark();
        good(8'h2B);
        chk("make_fk", 32'(fk1 - b_fk1), 32'd1);
        chk("make_fk_nosup", 32'(fk0 - b_fk0), 32'd1);
        chk("make_scancode", 32'(scancode), 32'h2B);
        chk("make_ext", 32'(extended), 32'h0);
        chk("make_err", 32'(err1 - b_err), 32'd0);

        // Break 2B
        mark();
        good(8'hF0);
        chk("brk_f0_fk", 32'(fk1 - b_fk1), 32'd0);
        chk("brk_f0_rel", 32'(rel1 - b_rel), 32'd0);
        good(8'h2B);
        chk("brk_rel", 32'(rel1 - b_rel), 32'd1);
        chk("brk_fk", 32'(fk1 - b_fk1), 32'd0);
        chk("brk_scancode", 32'(scancode), 32'h2B);
        mark();
        good(8'h2B);
        chk("remake_fk", 32'(fk1 - b_fk1), 32'd1);

        // Typematic 2D x3
        mark();
        good(8'h2D);
        good(8'h2D);
        good(8'h2D);
        chk("typ_fk_sup", 32'(fk1 - b_fk1), 32'd1);
        chk("typ_fk_nosup", 32'(fk0 - b_fk0), 32'd3);
        chk("typ_scancode", 32'(scancode), 32'h2D);
        mark();
        good(8'hF0);
        good(8'h2D);
        chk("typ_rel", 32'(rel1 - b_rel), 32'd1);
        good(8'h2D);
        chk("typ_refk", 32'(fk1 - b_fk1), 32'd1);

        // Parity error
        mark();
        send(8'h2D, 1'b0, 1'b1, 11);
        chk("par_err", 32'(err1 - b_err), 32'd1);
        chk("par_fk", 32'(fk1 - b_fk1), 32'd0);
        chk("par_scancode", 32'(scancode), 32'h2D);
        mark();
        good(8'h2B);
        chk("par_next_fk", 32'(fk1 - b_fk1), 32'd1);
        chk("par_next_sc", 32'(scancode), 32'h2B);

        // Timeout after start + 4 data bits
        mark();
        send(8'h2D, 1'b1, 1'b1, 5);
        wait_cyc(TO + 10);
        chk("to_err", 32'(err1 - b_err), 32'd1);
        chk("to_fk", 32'(fk1 - b_fk1), 32'd0);
        mark();
        good(8'h2D);
        chk("to_next_fk", 32'(fk1 - b_fk1), 32'd1);
        chk("to_next_sc", 32'(scancode), 32'h2D);
        chk("to_next_err", 32'(err1 - b_err), 32'd0);

        // Extended key, then reset mid-frame
        mark();
        good(8'hE0);
        good(8'h75);
        chk("ext_fk", 32'(fk1 - b_fk1), 32'd1);
        chk("ext_sc", 32'(scancode), 32'h75);
        chk("ext_flag", 32'(extended), 32'h1);
        send(8'h2B, 1'b1, 1'b1, 6);
        #2 reset = 1'b1;
        #1;
        chk("mrst_scancode", 32'(scancode), 32'h0);
        chk("mrst_extended", 32'(extended), 32'h0);
        chk("mrst_strobes", 32'({flagkey, keyrelease, frame_err}), 32'h0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(5);
        mark();
        good(8'h2B);
        chk("post_rst_fk", 32'(fk1 - b_fk1), 32'd1);
        chk("post_rst_sc", 32'(scancode), 32'h2B);
        chk("post_rst_ext", 32'(extended), 32'h0);
        chk("post_rst_err", 32'(err1 - b_err), 32'd0);

        chk("strobe_overlap", 32'(ovl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
